// File: rtl/seq_dp_pkg.sv
// Shared types and opcode helpers for the sequenced bus datapath.
package seq_dp_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_NOT = 4'd6,
    OP_NEG = 4'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T_A  = 2'd1,
    T_B  = 2'd2,
    T_C  = 2'd3
  } state_t;

  // Codes 8..15 are reserved and rejected with an err pulse.
  function automatic logic is_legal(input logic [3:0] op);
    return ~op[3];
  endfunction

  // Unary ops take only the B operand, so the Y-load step is skipped.
  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/seq_dp_alu.sv
// Combinational ALU: result = f(op, Y, B), all arithmetic modulo 2^WIDTH.
module seq_dp_alu
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;

  // Shift distance uses only the low bits of B.
  assign shamt = b[SH_W-1:0];

  // Opcode decode; illegal codes never reach here but yield zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = y + b;
      OP_SUB:  result = y - b;
      OP_AND:  result = y & b;
      OP_OR:   result = y | b;
      OP_SHL:  result = y << shamt;
      OP_SHR:  result = y >> shamt;
      OP_NOT:  result = ~b;
      OP_NEG:  result = '0 - b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/param_seq_datapath.sv
// Register file, Y/Z registers and ALU on one internal bus, sequenced by a
// small control-step FSM so a single start pulse performs Rc <= Ra op Rb.
module param_seq_datapath
  import seq_dp_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [IDX_W-1:0] ra,
  input  logic [IDX_W-1:0] rb,
  input  logic [IDX_W-1:0] rc,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] z_out
);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [IDX_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [WIDTH-1:0] y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             done_q, done_d, err_q, err_d;
  logic             step_a, step_b, step_c;
  logic             accept;
  logic [WIDTH-1:0] bus, alu_res;

  // A start counts only in IDLE; a simultaneous direct load takes priority.
  assign accept = (state_q == IDLE) && start && !load_en;

  // Next-state logic: binary ops visit T_A to load Y, unary ops skip it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_legal(op)) state_d = is_unary(op) ? T_B : T_A;
      T_A:     state_d = T_B;
      T_B:     state_d = T_C;
      T_C:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: one-hot step strobes select the bus driver.
  always_comb begin
    step_a = (state_q == T_A);
    step_b = (state_q == T_B);
    step_c = (state_q == T_C);
    busy   = (state_q != IDLE);
  end

  // In IDLE no step is active and the bus reads as zero rather than floating.
  assign bus = ({WIDTH{step_a}} & regs_q[ra_q])
             | ({WIDTH{step_b}} & regs_q[rb_q])
             | ({WIDTH{step_c}} & z_q);

  seq_dp_alu #(.WIDTH(WIDTH)) u_alu (
    .y      (y_q),
    .b      (bus),
    .op     (op_q),
    .result (alu_res)
  );

  // Datapath next values: command latch, loads, Y/Z capture, writeback.
  always_comb begin
    op_d   = op_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    rc_d   = rc_q;
    y_d    = y_q;
    z_d    = z_q;
    regs_d = regs_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (accept) begin
      if (is_legal(op)) begin
        op_d = op;
        ra_d = ra;
        rb_d = rb;
        rc_d = rc;
      end else begin
        err_d = 1'b1;
      end
    end
    if ((state_q == IDLE) && load_en) regs_d[load_idx] = load_data;
    if (step_a) y_d = bus;
    if (step_b) z_d = alu_res;
    if (step_c) begin
      regs_d[rc_q] = bus;
      done_d       = 1'b1;
    end
  end

  // State register; clr clears everything and abandons any operation.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      regs_q  <= '{default: '0};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      y_q     <= y_d;
      z_q     <= z_d;
      regs_q  <= regs_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rd_data = regs_q[rd_idx];
  assign done    = done_q;
  assign err     = err_q;
  assign z_out   = z_q;

endmodule

// File: tb/tb_param_seq_datapath.sv
// Bench for param_seq_datapath: directed steps plus randomized ops, checked
// against an arithmetic reference model of the register file.
module tb_param_seq_datapath;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  // 32-bit / 16-register instance
  logic        clr, start, load_en;
  logic [3:0]  op, ra, rb, rc, load_idx, rd_idx;
  logic [31:0] load_data, rd_data, z_out;
  logic        busy, done, err;

  // 16-bit / 8-register instance
  logic        clr2, start2, load_en2;
  logic [3:0]  op2;
  logic [2:0]  ra2, rb2, rc2, load_idx2, rd_idx2;
  logic [15:0] load_data2, rd_data2, z_out2;
  logic        busy2, done2, err2;

  param_seq_datapath #(.WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .z_out(z_out)
  );

  param_seq_datapath #(.WIDTH(16), .NUM_REGS(8)) dut2 (
    .clk(clk), .clr(clr2), .start(start2), .op(op2), .ra(ra2), .rb(rb2), .rc(rc2),
    .load_en(load_en2), .load_idx(load_idx2), .load_data(load_data2),
    .rd_idx(rd_idx2), .rd_data(rd_data2), .busy(busy2), .done(done2), .err(err2),
    .z_out(z_out2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mdl  [16];
  logic [63:0] mdl2 [8];

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: observed timeout required summary");
    $fatal(1, "watchdog");
  end

  // Reference: the opcode table evaluated with plain arithmetic mod 2^w.
  function automatic logic [63:0] ref_alu(int o, logic [63:0] a, logic [63:0] b, int w);
    logic [63:0] m, sh, r;
    m  = (64'd1 << w) - 64'd1;
    sh = b % 64'(w);
    case (o)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a << sh;
      5:       r = a >> sh;
      6:       r = ~b;
      7:       r = 64'd0 - b;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(int idx, logic [63:0] data);
    load_en = 1'b1; load_idx = 4'(idx); load_data = data[31:0];
    tick();
    load_en = 1'b0;
    mdl[idx] = {32'd0, data[31:0]};
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk(tag, 64'(rd_data), mdl[i]);
    end
  endtask

  // Issue one legal op and return in the cycle where done is high.
  task automatic run_op(int o, int a, int b, int c);
    int cnt, exp_lat;
    logic [63:0] res;
    exp_lat = (o >= 6) ? 2 : 3;
    res = ref_alu(o, mdl[a], mdl[b], 32);
    start = 1'b1; op = 4'(o); ra = 4'(a); rb = 4'(b); rc = 4'(c);
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    cnt = 0;
    while (!done && cnt < 8) begin
      tick();
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(exp_lat));
    chk("z_out", 64'(z_out), res);
    chk("busy_at_done", 64'(busy), 64'd0);
    mdl[c] = res;
    rd_idx = 4'(c);
    #1;
    chk("result", 64'(rd_data), res);
  endtask

  task automatic run_ill(int o);
    start = 1'b1; op = 4'(o);
    tick();
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'd1);
    chk("busy_illegal", 64'(busy), 64'd0);
    tick();
    chk("err_clear", 64'(err), 64'd0);
  endtask

  task automatic load2(int idx, logic [63:0] data);
    load_en2 = 1'b1; load_idx2 = 3'(idx); load_data2 = data[15:0];
    tick();
    load_en2 = 1'b0;
    mdl2[idx] = {48'd0, data[15:0]};
  endtask

  task automatic run2(int o, int a, int b, int c);
    int cnt, exp_lat;
    logic [63:0] res;
    exp_lat = (o >= 6) ? 2 : 3;
    res = ref_alu(o, mdl2[a], mdl2[b], 16);
    start2 = 1'b1; op2 = 4'(o); ra2 = 3'(a); rb2 = 3'(b); rc2 = 3'(c);
    tick();
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 8) begin
      tick();
      cnt++;
    end
    chk("w16_latency", 64'(cnt), 64'(exp_lat));
    mdl2[c] = res;
    rd_idx2 = 3'(c);
    #1;
    chk("w16_result", 64'(rd_data2), res);
  endtask

  initial begin
    logic [63:0] v;
    int r;
    clr = 1'b1; start = 1'b0; load_en = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    load_idx = '0; load_data = '0; rd_idx = '0;
    clr2 = 1'b1; start2 = 1'b0; load_en2 = 1'b0; op2 = '0; ra2 = '0; rb2 = '0; rc2 = '0;
    load_idx2 = '0; load_data2 = '0; rd_idx2 = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 64'd0;
    for (int i = 0; i < 8; i++) mdl2[i] = 64'd0;
    tick(); tick();
    clr = 1'b0; clr2 = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_z", 64'(z_out), 64'd0);

    // Reset after a load clears the register
    load(1, 64'd5);
    rd_idx = 4'd1; #1;
    chk("load_r1", 64'(rd_data), 64'd5);
    clr = 1'b1; tick(); clr = 1'b0;
    mdl[1] = 64'd0;
    rd_idx = 4'd1; #1;
    chk("clr_r1", 64'(rd_data), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_z", 64'(z_out), 64'd0);

    // NEG then NOT
    load(1, 64'h7);
    run_op(7, 0, 1, 0);
    chk("neg_r0", mdl[0], 64'hFFFF_FFF9);
    tick();
    run_op(6, 0, 1, 2);
    chk("not_r2", mdl[2], 64'hFFFF_FFF8);
    tick();

    // Binary with destination equal to a source
    load(3, 64'hFFFF_FFFF);
    load(4, 64'd2);
    run_op(0, 3, 4, 3);
    chk("add_r3", mdl[3], 64'h1);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    load(3, 64'hFFFF_FFFF);
    load(4, 64'd36);
    run_op(4, 3, 4, 3);
    chk("shl_r3", mdl[3], 64'hFFFF_FFF0);
    tick();
    check_all("regs_after_directed");

    // Illegal op, then start colliding with a load
    run_ill(9);
    check_all("regs_after_illegal");
    start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd1; rc = 4'd5;
    load_en = 1'b1; load_idx = 4'd5; load_data = 32'hA5;
    tick();
    start = 1'b0; load_en = 1'b0;
    mdl[5] = 64'hA5;
    chk("conflict_busy", 64'(busy), 64'd0);
    chk("conflict_err", 64'(err), 64'd0);
    tick();
    chk("conflict_done", 64'(done), 64'd0);
    check_all("regs_after_conflict");

    // SUB disturbed by a load in T_A and clr in T_B
    start = 1'b1; op = 4'd1; ra = 4'd1; rb = 4'd2; rc = 4'd6;
    tick();
    start = 1'b0;
    load_en = 1'b1; load_idx = 4'd7; load_data = 32'h1234;
    tick();
    load_en = 1'b0;
    rd_idx = 4'd7; #1;
    chk("busy_load_ignored", 64'(rd_data), mdl[7]);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 64'd0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_z", 64'(z_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      tick();
    end
    check_all("regs_after_abort");

    // Back-to-back: second op starts in the done cycle and uses the result
    load(8, 64'h1000_0001);
    load(9, 64'h0000_00F3);
    run_op(1, 8, 9, 10);
    run_op(3, 10, 9, 11);
    run_op(7, 0, 11, 12);
    tick();
    check_all("regs_after_b2b");

    // Randomized mix of loads, legal ops and illegal ops
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        case ($urandom_range(0, 3))
          0:       v = 64'd0;
          1:       v = 64'hFFFF_FFFF;
          default: v = 64'($urandom);
        endcase
        load($urandom_range(0, 15), v);
      end else if (r == 2) begin
        run_ill($urandom_range(8, 15));
      end else begin
        run_op($urandom_range(0, 7), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    tick();
    check_all("regs_after_random");

    // Narrow instance
    load2(1, 64'h0001);
    load2(2, 64'h0002);
    run2(1, 1, 2, 3);
    chk("w16_sub", mdl2[3], 64'hFFFF);
    load2(4, 64'h0013);
    run2(4, 3, 4, 5);
    chk("w16_shl", mdl2[5], 64'hFFF8);
    run2(5, 3, 4, 6);
    run2(7, 0, 2, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
